// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the out-of-order issue queue.
// Also holds the operand mux that builds an issue packet from a queue entry.
package issue_queue_pkg;

    localparam int IqDepth         = 4;
    localparam int WriteBackPorts  = 2;
    localparam int ScoreboardDepth = 8;
    localparam int TagW            = $clog2(ScoreboardDepth);

    typedef enum logic [2:0] {
        FU_NONE,
        FU_ALU,
        FU_BJU,
        FU_MDU,
        FU_CSR,
        FU_LOAD,
        FU_STORE
    } fu_e;

    typedef struct packed {
        logic [TagW-1:0] idx;
        fu_e             fu;
        logic [3:0]      op;
        logic [4:0]      rs1;
        logic [31:0]     imm;
        logic [31:0]     pc;
        logic            use_pc;
        logic            use_imm;
        logic            use_zimm;
    } decoder_t;

    typedef struct packed {
        logic [TagW-1:0] idx;
        fu_e             fu;
        logic [3:0]      op;
        logic [31:0]     operand_a;
        logic [31:0]     operand_b;
        logic [31:0]     imm;
    } fu_data_t;

    typedef struct packed {
        logic                 valid;
        decoder_t             instr;
        logic [1:0]           rs_ready;
        logic [1:0][TagW-1:0] rs_tag;
        logic [1:0][31:0]     rs_data;
    } iq_entry_t;

    function automatic logic is_lsu(input fu_e fu);
        return (fu == FU_LOAD) || (fu == FU_STORE);
    endfunction

    // Stores and branches keep rs2 in operand_b; their imm travels separately.
    function automatic fu_data_t build_fu_data(input iq_entry_t e);
        fu_data_t d;
        d.idx       = e.instr.idx;
        d.fu        = e.instr.fu;
        d.op        = e.instr.op;
        d.imm       = e.instr.imm;
        d.operand_a = e.rs_data[0];
        d.operand_b = e.rs_data[1];
        if (e.instr.use_pc)
            d.operand_a = e.instr.pc;
        else if (e.instr.use_zimm)
            d.operand_a = {27'b0, e.instr.rs1};
        if (e.instr.use_imm && (e.instr.fu != FU_STORE) && (e.instr.fu != FU_BJU))
            d.operand_b = e.instr.imm;
        return d;
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode-side enqueue, writeback snoop and execute-side issue signals of the issue queue.
// Handshake: an instr moves on a clock edge where enq_valid & enq_ready; issue pulses need no ack.
interface issue_queue_if
    import issue_queue_pkg::*;
#(
    parameter int Depth   = IqDepth,
    parameter int WbPorts = WriteBackPorts
);
    localparam int CntW = $clog2(Depth) + 1;

    logic                             flush;
    logic                             enq_valid;
    logic                             enq_ready;
    decoder_t                         enq_instr;
    logic [1:0]                       enq_rs_ready;
    logic [1:0][TagW-1:0]             enq_rs_tag;
    logic [1:0][31:0]                 enq_rs_data;
    logic [WbPorts-1:0]               wb_valid;
    logic [WbPorts-1:0][TagW-1:0]     wb_idx;
    logic [WbPorts-1:0][31:0]         wb_data;
    logic                             flu_ready;
    logic                             lsu_ready;
    fu_data_t                         flu_data;
    fu_data_t                         lsu_data;
    logic                             alu_valid;
    logic                             bju_valid;
    logic                             mdu_valid;
    logic                             csr_valid;
    logic                             lsu_valid;
    logic [CntW-1:0]                  count;

    modport master (
        output flush, enq_valid, enq_instr, enq_rs_ready, enq_rs_tag, enq_rs_data,
               wb_valid, wb_idx, wb_data, flu_ready, lsu_ready,
        input  enq_ready, flu_data, lsu_data, alu_valid, bju_valid, mdu_valid,
               csr_valid, lsu_valid, count
    );

    modport slave (
        input  flush, enq_valid, enq_instr, enq_rs_ready, enq_rs_tag, enq_rs_data,
               wb_valid, wb_idx, wb_data, flu_ready, lsu_ready,
        output enq_ready, flu_data, lsu_data, alu_valid, bju_valid, mdu_valid,
               csr_valid, lsu_valid, count
    );

endinterface

// File: rtl/issue_queue_age_select.sv
// Age matrix over queue slots plus an oldest-requester picker.
// older[i][j] = 1 means slot i was enqueued before slot j.
module iq_age_select #(
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [Depth-1:0] alloc,
    input  logic [Depth-1:0] free,
    input  logic [Depth-1:0] valid,
    input  logic [Depth-1:0] req,
    output logic [Depth-1:0] grant
);

    logic [Depth-1:0][Depth-1:0] older;

    // A new slot is younger than every slot that stays valid across this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            older <= '0;
        end else if (flush) begin
            older <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                for (int j = 0; j < Depth; j++) begin
                    if (alloc[i])
                        older[i][j] <= 1'b0;
                    else if (alloc[j])
                        older[i][j] <= valid[i] & ~free[i];
                    else if (free[i] || free[j])
                        older[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        grant = req;
        for (int i = 0; i < Depth; i++) begin
            for (int j = 0; j < Depth; j++) begin
                if (req[j] && older[j][i])
                    grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Windowed out-of-order issue queue: tag-tracked operand wakeup from writeback,
// oldest-ready select for the FLU channel and in-order select for the LSU channel.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int Depth   = IqDepth,
    parameter int WbPorts = WriteBackPorts
) (
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave iq
);

    localparam int CntW = $clog2(Depth) + 1;
    localparam int IdxW = $clog2(Depth);

    iq_entry_t        entries   [Depth];
    iq_entry_t        entries_d [Depth];
    iq_entry_t        enq_entry;
    iq_entry_t        flu_sel;
    iq_entry_t        lsu_sel;
    logic [CntW-1:0]  count_q;
    logic [IdxW-1:0]  free_slot;
    logic [Depth-1:0] valid_vec;
    logic [Depth-1:0] ready_vec;
    logic [Depth-1:0] lsu_vec;
    logic [Depth-1:0] csr_vec;
    logic [Depth-1:0] flu_req;
    logic [Depth-1:0] flu_grant;
    logic [Depth-1:0] lsu_grant;
    logic [Depth-1:0] oldest;
    logic [Depth-1:0] alloc;
    logic [Depth-1:0] free;
    logic             enq_fire;
    logic             flu_issue;
    logic             lsu_issue;

    // Lowest matching writeback port wins: the loop runs high to low, last write sticks.
    function automatic iq_entry_t wake(
        input iq_entry_t                    e,
        input logic [WbPorts-1:0]           v,
        input logic [WbPorts-1:0][TagW-1:0] tag,
        input logic [WbPorts-1:0][31:0]     data
    );
        iq_entry_t r;
        r = e;
        for (int k = 0; k < 2; k++) begin
            if (!e.rs_ready[k]) begin
                for (int p = WbPorts - 1; p >= 0; p--) begin
                    if (v[p] && (tag[p] == e.rs_tag[k])) begin
                        r.rs_ready[k] = 1'b1;
                        r.rs_data[k]  = data[p];
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            valid_vec[i] = entries[i].valid;
            ready_vec[i] = &entries[i].rs_ready;
            lsu_vec[i]   = entries[i].valid && is_lsu(entries[i].instr.fu);
            csr_vec[i]   = entries[i].instr.fu == FU_CSR;
        end
    end

    // CSR ops serialise: they only compete once nothing older remains in the window.
    always_comb begin
        for (int i = 0; i < Depth; i++)
            flu_req[i] = valid_vec[i] && ready_vec[i] && !is_lsu(entries[i].instr.fu)
                         && (!csr_vec[i] || oldest[i]);
    end

    always_comb begin
        free_slot = '0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (!valid_vec[i])
                free_slot = IdxW'(i);
        end
    end

    assign iq.enq_ready = count_q < CntW'(Depth);
    assign iq.count     = count_q;
    assign enq_fire     = iq.enq_valid && iq.enq_ready && !iq.flush;
    assign flu_issue    = (|flu_grant) && iq.flu_ready && !iq.flush;
    assign lsu_issue    = (|(lsu_grant & ready_vec)) && iq.lsu_ready && !iq.flush;

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            alloc[i] = enq_fire && (free_slot == IdxW'(i));
            free[i]  = (flu_issue && flu_grant[i]) || (lsu_issue && lsu_grant[i]);
        end
    end

    always_comb begin
        flu_sel = '0;
        lsu_sel = '0;
        for (int i = 0; i < Depth; i++) begin
            if (flu_grant[i])
                flu_sel = entries[i];
            if (lsu_grant[i])
                lsu_sel = entries[i];
        end
    end

    always_comb begin
        enq_entry          = '0;
        enq_entry.valid    = 1'b1;
        enq_entry.instr    = iq.enq_instr;
        enq_entry.rs_ready = iq.enq_rs_ready;
        enq_entry.rs_tag   = iq.enq_rs_tag;
        enq_entry.rs_data  = iq.enq_rs_data;
        enq_entry          = wake(enq_entry, iq.wb_valid, iq.wb_idx, iq.wb_data);
    end

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            entries_d[i] = entries[i];
            if (iq.flush)
                entries_d[i] = '0;
            else if (alloc[i])
                entries_d[i] = enq_entry;
            else if (free[i])
                entries_d[i].valid = 1'b0;
            else if (entries[i].valid)
                entries_d[i] = wake(entries[i], iq.wb_valid, iq.wb_idx, iq.wb_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++)
                entries[i] <= '0;
        end else begin
            for (int i = 0; i < Depth; i++)
                entries[i] <= entries_d[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (iq.flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CntW'(enq_fire) - CntW'(flu_issue) - CntW'(lsu_issue);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iq.alu_valid <= 1'b0;
            iq.bju_valid <= 1'b0;
            iq.mdu_valid <= 1'b0;
            iq.csr_valid <= 1'b0;
            iq.lsu_valid <= 1'b0;
            iq.flu_data  <= '0;
            iq.lsu_data  <= '0;
        end else if (iq.flush) begin
            iq.alu_valid <= 1'b0;
            iq.bju_valid <= 1'b0;
            iq.mdu_valid <= 1'b0;
            iq.csr_valid <= 1'b0;
            iq.lsu_valid <= 1'b0;
            iq.flu_data  <= '0;
            iq.lsu_data  <= '0;
        end else begin
            // FU_NONE issues with every pulse low, which simply retires its slot.
            iq.alu_valid <= flu_issue && (flu_sel.instr.fu == FU_ALU);
            iq.bju_valid <= flu_issue && (flu_sel.instr.fu == FU_BJU);
            iq.mdu_valid <= flu_issue && (flu_sel.instr.fu == FU_MDU);
            iq.csr_valid <= flu_issue && (flu_sel.instr.fu == FU_CSR);
            iq.lsu_valid <= lsu_issue;
            if (flu_issue)
                iq.flu_data <= build_fu_data(flu_sel);
            if (lsu_issue)
                iq.lsu_data <= build_fu_data(lsu_sel);
        end
    end

    iq_age_select #(.Depth(Depth)) u_flu_select (
        .clk   (clk),
        .rst   (rst),
        .flush (iq.flush),
        .alloc (alloc),
        .free  (free),
        .valid (valid_vec),
        .req   (flu_req),
        .grant (flu_grant)
    );

    // The LSU picker sees every LSU entry, ready or not, so memory ops never pass each other.
    iq_age_select #(.Depth(Depth)) u_lsu_select (
        .clk   (clk),
        .rst   (rst),
        .flush (iq.flush),
        .alloc (alloc),
        .free  (free),
        .valid (valid_vec),
        .req   (lsu_vec),
        .grant (lsu_grant)
    );

    iq_age_select #(.Depth(Depth)) u_oldest_select (
        .clk   (clk),
        .rst   (rst),
        .flush (iq.flush),
        .alloc (alloc),
        .free  (free),
        .valid (valid_vec),
        .req   (valid_vec),
        .grant (oldest)
    );

endmodule
